// File: rtl/mc_controller_if.sv
// Control-unit bus: instruction/flag/handshake inputs and datapath control outputs.
// The slave modport is the controller's view; master is the datapath/bench side.
interface mc_controller_if #(
    parameter int unsigned CNT_W = 32
) ();
    logic [10:0]      Op;
    logic             zero_E;
    logic             imem_ready;
    logic             dmem_ready;
    logic             IMemRead;
    logic             IRWrite;
    logic             Reg2Loc;
    logic             AluSrc;
    logic             RegWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             MemtoReg;
    logic [3:0]       AluControl;
    logic             PCWrite;
    logic             PCSrc;
    logic             Exc;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    modport slave (
        input  Op, zero_E, imem_ready, dmem_ready,
        output IMemRead, IRWrite, Reg2Loc, AluSrc, RegWrite, MemRead, MemWrite,
               MemtoReg, AluControl, PCWrite, PCSrc, Exc, state, retired
    );

    modport master (
        output Op, zero_E, imem_ready, dmem_ready,
        input  IMemRead, IRWrite, Reg2Loc, AluSrc, RegWrite, MemRead, MemWrite,
               MemtoReg, AluControl, PCWrite, PCSrc, Exc, state, retired
    );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle LEGv8-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
// sticky invalid-opcode trap and a wrapping retired-instruction counter.
module mc_controller #(
    parameter int unsigned CNT_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    mc_controller_if.slave bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_NONE,
        C_LDUR,
        C_STUR,
        C_ADD,
        C_SUB,
        C_AND,
        C_ORR,
        C_CBZ,
        C_B,
        C_INV
    } cls_t;

    state_t           state_q, state_d;
    cls_t             class_q, class_d;
    cls_t             op_class;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic       imem_read, ir_write, reg2loc, alu_src, reg_write;
    logic       mem_read, mem_write, mem_to_reg, pc_write, pc_src, exc;
    logic [3:0] alu_ctl;

    always_comb begin
        op_class = C_INV;
        if (bus.Op == 11'b11111000010)      op_class = C_LDUR;
        else if (bus.Op == 11'b11111000000) op_class = C_STUR;
        else if (bus.Op == 11'b10001011000) op_class = C_ADD;
        else if (bus.Op == 11'b11001011000) op_class = C_SUB;
        else if (bus.Op == 11'b10001010000) op_class = C_AND;
        else if (bus.Op == 11'b10101010000) op_class = C_ORR;
        else if (bus.Op[10:3] == 8'b10110100) op_class = C_CBZ;
        else if (bus.Op[10:5] == 6'b000101)   op_class = C_B;
    end

    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        imem_read  = 1'b0;
        ir_write   = 1'b0;
        reg2loc    = 1'b0;
        alu_src    = 1'b0;
        alu_ctl    = 4'b0000;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        exc        = 1'b0;

        // ALU controls follow the registered class through EXEC, MEM and WB
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            unique case (class_q)
                C_LDUR, C_STUR: begin alu_src = 1'b1; alu_ctl = 4'b0010; end
                C_ADD:          alu_ctl = 4'b0010;
                C_SUB:          alu_ctl = 4'b0110;
                C_AND:          alu_ctl = 4'b0000;
                C_ORR:          alu_ctl = 4'b0001;
                C_CBZ:          alu_ctl = 4'b0111;
                default:        alu_ctl = 4'b0000;
            endcase
        end

        case (state_q)
            S_FETCH: begin
                imem_read = 1'b1;
                if (bus.imem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                reg2loc = (op_class == C_STUR) || (op_class == C_CBZ);
                class_d = op_class;
                state_d = (op_class == C_INV) ? S_ERROR : S_EXEC;
            end
            S_EXEC: begin
                case (class_q)
                    C_LDUR, C_STUR:             state_d = S_MEM;
                    C_ADD, C_SUB, C_AND, C_ORR: state_d = S_WB;
                    C_CBZ: begin
                        pc_write = 1'b1;
                        pc_src   = bus.zero_E;
                        state_d  = S_FETCH;
                    end
                    C_B: begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default:                    state_d = S_ERROR;
                endcase
            end
            S_MEM: begin
                mem_read  = (class_q == C_LDUR);
                mem_write = (class_q == C_STUR);
                if (bus.dmem_ready) begin
                    if (class_q == C_LDUR) begin
                        state_d = S_WB;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (class_q == C_LDUR);
                pc_write   = 1'b1;
                state_d    = S_FETCH;
            end
            S_ERROR: begin
                exc = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        retired_d = pc_write ? retired_q + CNT_W'(1) : retired_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            class_q   <= C_NONE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            retired_q <= retired_d;
        end
    end

    // Controls are gated by reset so they drop asynchronously, not at the next edge
    assign bus.IMemRead   = reset & imem_read;
    assign bus.IRWrite    = reset & ir_write;
    assign bus.Reg2Loc    = reset & reg2loc;
    assign bus.AluSrc     = reset & alu_src;
    assign bus.AluControl = reset ? alu_ctl : 4'b0000;
    assign bus.RegWrite   = reset & reg_write;
    assign bus.MemRead    = reset & mem_read;
    assign bus.MemWrite   = reset & mem_write;
    assign bus.MemtoReg   = reset & mem_to_reg;
    assign bus.PCWrite    = reset & pc_write;
    assign bus.PCSrc      = reset & pc_src;
    assign bus.Exc        = reset & exc;
    assign bus.state      = state_q;
    assign bus.retired    = retired_q;

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter CNT_W, default 32: width of retired-instruction counter.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 Op  in  11  opcode field of the instruction register; valid from DECODE onward.
REQ-005 zero_E  in  1  zero flag from the execute stage.
REQ-006 imem_ready  in  1  instruction memory handshake; fetched word valid this cycle.
REQ-007 dmem_ready  in  1  data memory handshake; access completes this cycle.
REQ-008 IMemRead  out  1  instruction fetch request.
REQ-009 IRWrite  out  1  load instruction register.
REQ-010 Reg2Loc, AluSrc, RegWrite, MemRead, MemWrite, MemtoReg  out  1 each  datapath controls.
REQ-011 AluControl  out  4  execute-stage ALU operation.
REQ-012 PCWrite  out  1  update PC; PCSrc  out  1  0 = PC+4, 1 = PCBranch_E.
REQ-013 Exc  out  1  sticky invalid-opcode flag.
REQ-014 state  out  3  current FSM state, for debug.
REQ-015 retired  out  CNT_W  count of completed instructions.

Function
REQ-016 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERROR=5; codes 6-7 SHALL go to FETCH on the next edge.
REQ-017 Opcode classes, decoded in DECODE and held in a register until the next DECODE:
- LDUR 11111000010, STUR 11111000000
- ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000
- CBZ 10110100xxx, B 000101xxxxx
- anything else is invalid.
REQ-018 FETCH: IMemRead=1. Stay while imem_ready=0. When imem_ready=1: IRWrite=1 for that cycle, next state DECODE.
REQ-019 DECODE: Reg2Loc=1 for STUR and CBZ, else 0. Valid opcode goes to EXEC; invalid opcode goes to ERROR.
REQ-020 EXEC, AluSrc and AluControl by class:
- LDUR/STUR: AluSrc=1, AluControl=0010.
- ADD 0010, SUB 0110, AND 0000, ORR 0001, all with AluSrc=0.
- CBZ: AluSrc=0, AluControl=0111 (pass B).
- B: AluControl=0000, no register effect.
REQ-021 EXEC next state:
- LDUR/STUR go to MEM; R-type goes to WB.
- CBZ: PCWrite=1, PCSrc=zero_E, next FETCH.
- B: PCWrite=1, PCSrc=1, next FETCH.
REQ-022 MEM: MemRead=1 (LDUR) or MemWrite=1 (STUR); stay while dmem_ready=0.
- On dmem_ready=1, LDUR goes to WB.
- On dmem_ready=1, STUR asserts PCWrite=1, PCSrc=0, next FETCH.
REQ-023 WB: RegWrite=1, MemtoReg=1 for LDUR else 0, PCWrite=1, PCSrc=0; next FETCH.
REQ-024 AluSrc/AluControl SHALL be held at their EXEC values during MEM and WB; all other outputs not listed for a state SHALL be 0.
REQ-025 PCWrite SHALL pulse exactly once per instruction, in its final cycle.
REQ-026 retired SHALL increment on every PCWrite cycle and wrap from 2^CNT_W-1 to 0.
REQ-027 Latency without waits: R-type 4 cycles, LDUR 5, STUR 4, CBZ/B 3. Each cycle of imem_ready=0 or dmem_ready=0 adds exactly one cycle.
REQ-028 ERROR: Exc=1, all other controls 0, state held until reset; retired frozen.
REQ-029 Op changes outside DECODE SHALL NOT affect the instruction in progress.
REQ-030 All outputs except state and retired SHALL be combinational functions of state and registered class (Moore).

Reset
REQ-031 reset=0 SHALL immediately force state=FETCH, class=none, Exc=0, retired=0 and all control outputs to 0, including in mid-instruction and while waiting on memory.
REQ-032 On the first rising edge after reset rises, the block SHALL be in FETCH with IMemRead=1; no PCWrite pulse before the first completed fetch.

Verification
REQ-033 Reset, then ADD Op=10001011000 with imem_ready=1 -> states 0,1,2,4. In EXEC AluControl=0010, AluSrc=0. WB has RegWrite=1, PCWrite=1, PCSrc=0. retired=1.
REQ-034 LDUR with dmem_ready low 2 cycles in MEM -> 7 cycles total, MemRead=1 for 3 cycles. WB MemtoReg=1, AluSrc=1, AluControl=0010.
REQ-035 CBZ with zero_E=1, then CBZ with zero_E=0 -> EXEC PCSrc=1 then 0, Reg2Loc=1 in DECODE, 3 cycles each, retired=2.
REQ-036 Op=00000000000 in DECODE -> state=5, Exc=1 on the next cycle, held for 10 cycles; reset=0 clears Exc and gives state=0.
REQ-037 reset=0 asserted mid-MEM of STUR -> MemWrite drops the same cycle with no clock edge. After release: FETCH, retired unchanged from 0.
REQ-038 CNT_W=4, run 17 B instructions -> retired wraps to 1, PCWrite pulses every 3rd cycle.
